// File: rtl/intt_addrgen_if.sv
// Operand-read / write-back bus between the INTT address generator and its user.
// The master side drives start/valid; the slave side (the generator) drives everything else.
interface intt_addrgen_if #(
    parameter int unsigned LOG_N = 8
);
    logic               start;
    logic               valid;
    logic               rd_en;
    logic [LOG_N-1:0]   rd_addr_a;
    logic [LOG_N-1:0]   rd_addr_b;
    logic [LOG_N-2:0]   tw_addr;
    logic               last_stage;
    logic               wr_en;
    logic [LOG_N-1:0]   wr_addr_a;
    logic [LOG_N-1:0]   wr_addr_b;
    logic [4:0]         stage;
    logic               busy;
    logic               done;

    modport master (
        output start, valid,
        input  rd_en, rd_addr_a, rd_addr_b, tw_addr, last_stage,
        input  wr_en, wr_addr_a, wr_addr_b, stage, busy, done
    );

    modport slave (
        input  start, valid,
        output rd_en, rd_addr_a, rd_addr_b, tw_addr, last_stage,
        output wr_en, wr_addr_a, wr_addr_b, stage, busy, done
    );
endinterface

// File: rtl/intt_addrgen.sv
// Gentleman-Sande inverse-NTT address generator: issues butterfly operand reads stage by
// stage and replays them as write-back addresses after the butterfly pipeline latency.
module intt_addrgen #(
    parameter int unsigned LOG_N   = 8,
    parameter int unsigned BFU_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    intt_addrgen_if.slave bus
);
    localparam int unsigned AW   = LOG_N;
    localparam int unsigned TW   = LOG_N - 1;
    localparam int unsigned BW   = LOG_N - 1;
    localparam int unsigned SW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned HALF = 1 << (LOG_N - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [BW-1:0] bf_q, bf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            stage_q <= '0;
            bf_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bf_q    <= bf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: stage/butterfly sequencing and fixed-length drain between stages
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bf_d    = bf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    stage_d = '0;
                    bf_d    = '0;
                end
            end
            READ: begin
                if (bus.valid) begin
                    bf_d = bf_q + BW'(1);
                    if (bf_q == BW'(HALF - 1)) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == CW'(BFU_LAT - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOG_N - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        stage_d = stage_q + SW'(1);
                        bf_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    logic          in_read;
    logic [AW-1:0] bf_ext;
    logic [AW-1:0] lo_mask;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] span;
    logic [SW-1:0] tw_shift;

    // Read-side addresses; all zero outside READ so idle outputs stay quiet
    always_comb begin
        in_read  = (state_q == READ);
        bf_ext   = AW'(bf_q);
        span     = AW'(1) << stage_q;
        lo_mask  = span - AW'(1);
        addr_a   = ((bf_ext >> stage_q) << (stage_q + SW'(1))) + (bf_ext & lo_mask);
        tw_shift = SW'(LOG_N - 1) - stage_q;

        bus.rd_en      = in_read & bus.valid;
        bus.rd_addr_a  = in_read ? addr_a : '0;
        bus.rd_addr_b  = in_read ? addr_a + span : '0;
        bus.tw_addr    = in_read ? TW'((bf_ext & lo_mask) << tw_shift) : '0;
        bus.last_stage = in_read && (stage_q == SW'(LOG_N - 1));
        bus.stage      = stage_q;
        bus.busy       = (state_q == READ) || (state_q == DRAIN);
        bus.done       = (state_q == DONE);
    end

    logic [BFU_LAT-1:0] wen_q;
    logic [AW-1:0]      wa_q [BFU_LAT];
    logic [AW-1:0]      wb_q [BFU_LAT];

    // Write-back delay line; addresses are stored pre-gated so bubbles carry zero addresses
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(BFU_LAT); i++) begin
                wen_q[i] <= 1'b0;
                wa_q[i]  <= '0;
                wb_q[i]  <= '0;
            end
        end else begin
            wen_q[0] <= bus.rd_en;
            wa_q[0]  <= bus.rd_en ? bus.rd_addr_a : '0;
            wb_q[0]  <= bus.rd_en ? bus.rd_addr_b : '0;
            for (int i = 1; i < int'(BFU_LAT); i++) begin
                wen_q[i] <= wen_q[i-1];
                wa_q[i]  <= wa_q[i-1];
                wb_q[i]  <= wb_q[i-1];
            end
        end
    end

    always_comb begin
        bus.wr_en     = wen_q[BFU_LAT-1];
        bus.wr_addr_a = wa_q[BFU_LAT-1];
        bus.wr_addr_b = wb_q[BFU_LAT-1];
    end
endmodule

// File: tb/tb_intt_addrgen.sv
// Directed bench for intt_addrgen at LOG_N=3, BFU_LAT=2 with hand-computed read/write tables.
module tb_intt_addrgen;
    localparam int unsigned LOG_N   = 3;
    localparam int unsigned BFU_LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    intt_addrgen_if #(.LOG_N(LOG_N)) bus ();

    intt_addrgen #(.LOG_N(LOG_N), .BFU_LAT(BFU_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Butterfly k of the pass (stage k/4): top index, bottom index, twiddle index
    int pa  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int pb  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int ptw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    int exp_rd [12];
    int exp_done;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string t);
        check({t, " rd_en"},      int'(bus.rd_en),      0);
        check({t, " rd_addr_a"},  int'(bus.rd_addr_a),  0);
        check({t, " rd_addr_b"},  int'(bus.rd_addr_b),  0);
        check({t, " tw_addr"},    int'(bus.tw_addr),    0);
        check({t, " last_stage"}, int'(bus.last_stage), 0);
        check({t, " wr_en"},      int'(bus.wr_en),      0);
        check({t, " wr_addr_a"},  int'(bus.wr_addr_a),  0);
        check({t, " wr_addr_b"},  int'(bus.wr_addr_b),  0);
        check({t, " stage"},      int'(bus.stage),      0);
        check({t, " busy"},       int'(bus.busy),       0);
        check({t, " done"},       int'(bus.done),       0);
    endtask

    // Cycle 0 carries start; outputs are sampled mid-cycle against the expected timeline
    task automatic run(input string nm, input int stall_lo, input int stall_hi,
                       input int rst_c, input int xs_a, input int xs_b, input int ncyc);
        int    ri;
        int    wi;
        string t;
        for (int c = 0; c < ncyc; c++) begin
            reset     = (c == rst_c);
            bus.start = (c == 0) || (c == xs_a) || (c == xs_b);
            bus.valid = !(c >= stall_lo && c <= stall_hi);
            #3;
            t = $sformatf("%s c%0d", nm, c);
            if (c == 0 || (rst_c >= 0 && c > rst_c)) begin
                check_idle(t);
            end else begin
                ri = -1;
                wi = -1;
                for (int k = 0; k < 12; k++) begin
                    if (exp_rd[k] == c) ri = k;
                    if (exp_rd[k] == c - int'(BFU_LAT)) wi = k;
                end
                check({t, " rd_en"}, int'(bus.rd_en), (ri >= 0) ? 1 : 0);
                if (ri >= 0) begin
                    check({t, " rd_addr_a"}, int'(bus.rd_addr_a), pa[ri]);
                    check({t, " rd_addr_b"}, int'(bus.rd_addr_b), pb[ri]);
                    check({t, " tw_addr"},   int'(bus.tw_addr),   ptw[ri]);
                    check({t, " stage"},     int'(bus.stage),     ri / 4);
                end
                check({t, " wr_en"},     int'(bus.wr_en),     (wi >= 0) ? 1 : 0);
                check({t, " wr_addr_a"}, int'(bus.wr_addr_a), (wi >= 0) ? pa[wi] : 0);
                check({t, " wr_addr_b"}, int'(bus.wr_addr_b), (wi >= 0) ? pb[wi] : 0);
                check({t, " done"},       int'(bus.done),       (c == exp_done) ? 1 : 0);
                check({t, " busy"},       int'(bus.busy),       (c >= 1 && c < exp_done) ? 1 : 0);
                check({t, " last_stage"}, int'(bus.last_stage),
                      (c >= exp_rd[8] && c <= exp_rd[11]) ? 1 : 0);
            end
            @(posedge clk);
            #1;
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.valid = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;

        exp_rd   = '{1, 2, 3, 4,  7, 8, 9, 10,  13, 14, 15, 16};
        exp_done = 19;
        run("plain", -1, -2, -1, -1, -1, 22);

        exp_rd   = '{1, 4, 5, 6,  9, 10, 11, 12,  15, 16, 17, 18};
        exp_done = 21;
        run("stall", 2, 3, -1, -1, -1, 24);

        exp_rd   = '{1, 2, 3, 4,  7, 8, 9, 10,  13, 14, 15, 16};
        exp_done = 19;
        run("xstart", -1, -2, -1, 5, 19, 24);

        run("abort", -1, -2, 9, 9, -1, 15);

        run("rerun", -1, -2, -1, -1, -1, 22);

        run("rst_vs_start", -1, -2, 0, -1, -1, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
